// File: rtl/render_pkg.sv
// Shared types and constants for the render sequencer: FSM state encoding,
// the frame-start command word and the default frame geometry.
package render_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RENDER,
    DRAIN,
    DONE
  } state_e;

  localparam logic [15:0] CMD_UPDATE_FRAME = 16'h0001;
  localparam int          X_MAX_DEFAULT    = 1280;
  localparam int          Y_MAX_DEFAULT    = 720;

endpackage

// File: rtl/render_sequencer_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled RENDER cycles; trip is combinational
// on the STALL_LIMIT-th stalled cycle, abort is its registered one-cycle pulse.
module stall_watchdog #(
  parameter int STALL_LIMIT = 1023
) (
  input  logic gpuClock,
  input  logic reset,
  input  logic stall,
  output logic trip,
  output logic abort
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] count_q, count_d;
  logic          abort_q, abort_d;

  // Any non-stalled cycle (advance, or not rendering at all) clears the count.
  always_comb begin
    count_d = '0;
    if (stall) begin
      count_d = count_q + 1'b1;
    end
    abort_d = trip;
  end

  assign trip  = stall && (count_q == CW'(STALL_LIMIT - 1));
  assign abort = abort_q;

  always_ff @(posedge gpuClock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      abort_q <= 1'b0;
    end else begin
      count_q <= count_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: rtl/render_sequencer.sv
// render_sequencer: frame FSM producing the pipeline clock-enable and host status.
// Define RENDER_STALL_WDT_EN to build the stall watchdog that aborts a hung frame.
module render_sequencer
  import render_pkg::*;
#(
  parameter int X_MAX        = X_MAX_DEFAULT,
  parameter int Y_MAX        = Y_MAX_DEFAULT,
  parameter int COORD_W      = 11,
  parameter int DRAIN_CYCLES = 4
`ifdef RENDER_STALL_WDT_EN
  ,
  parameter int STALL_LIMIT  = 1023
`endif
) (
  input  logic               gpuClock,
  input  logic               reset,
  input  logic [15:0]        command,
  input  logic               cmdValid,
  input  logic               ramDone,
  input  logic               flashDone,
  input  logic               pixelFound,
  input  logic [COORD_W-1:0] paletteX,
  input  logic [COORD_W-1:0] paletteY,
  input  logic [COORD_W-1:0] ramX,
  input  logic [COORD_W-1:0] ramY,
  input  logic [COORD_W-1:0] flashX,
  input  logic [COORD_W-1:0] flashY,
  output logic               rstPixelInc,
  output logic               pipeAdvance,
  output logic               currentlyRendering,
  output logic               gpuBusy,
  output logic               frameDone,
  output logic               frameAbort,
  output logic [7:0]         frameCount
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            rst_pixel_inc_q, rst_pixel_inc_d;
  logic            pipe_advance_q, pipe_advance_d;
  logic            rendering_q, rendering_d;
  logic            gpu_busy_q, gpu_busy_d;
  logic            frame_done_q, frame_done_d;

  logic            pos_match, advance, last_pixel, wdt_trip;

  assign pos_match  = (paletteX == ramX) && (ramX == flashX) &&
                      (paletteY == ramY) && (ramY == flashY);
  assign advance    = (ramDone && flashDone) || (pixelFound && pos_match);
  assign last_pixel = pixelFound && (paletteX == COORD_W'(X_MAX - 1)) &&
                      (paletteY == COORD_W'(Y_MAX - 1));

`ifdef RENDER_STALL_WDT_EN
  logic stalled;
  assign stalled = (state_q == RENDER) && !advance;

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_watchdog (
    .gpuClock(gpuClock),
    .reset   (reset),
    .stall   (stalled),
    .trip    (wdt_trip),
    .abort   (frameAbort)
  );
`else
  assign wdt_trip   = 1'b0;
  assign frameAbort = 1'b0;
`endif

  // Every output is the registered image of the decision made in the current state.
  always_comb begin
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    frame_count_d   = frame_count_q;
    rst_pixel_inc_d = 1'b1;
    pipe_advance_d  = 1'b0;
    rendering_d     = 1'b0;
    frame_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmdValid && (command == CMD_UPDATE_FRAME)) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        rst_pixel_inc_d = 1'b0;
        rendering_d     = 1'b1;
        state_d         = RENDER;
      end
      RENDER: begin
        rendering_d    = 1'b1;
        pipe_advance_d = advance;
        drain_cnt_d    = '0;
        if (advance && last_pixel) begin
          state_d = DRAIN;
        end else if (wdt_trip) begin
          rendering_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        rendering_d    = 1'b1;
        pipe_advance_d = 1'b1;
        drain_cnt_d    = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    gpu_busy_d = rendering_d || !(ramDone && flashDone);
  end

  always_ff @(posedge gpuClock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      drain_cnt_q     <= '0;
      frame_count_q   <= '0;
      rst_pixel_inc_q <= 1'b1;
      pipe_advance_q  <= 1'b0;
      rendering_q     <= 1'b0;
      gpu_busy_q      <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      drain_cnt_q     <= drain_cnt_d;
      frame_count_q   <= frame_count_d;
      rst_pixel_inc_q <= rst_pixel_inc_d;
      pipe_advance_q  <= pipe_advance_d;
      rendering_q     <= rendering_d;
      gpu_busy_q      <= gpu_busy_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign rstPixelInc        = rst_pixel_inc_q;
  assign pipeAdvance        = pipe_advance_q;
  assign currentlyRendering = rendering_q;
  assign gpuBusy            = gpu_busy_q;
  assign frameDone          = frame_done_q;
  assign frameCount         = frame_count_q;

endmodule

// File: doc/render_sequencer.md
RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 Parameter X_MAX, default 1280, horizontal pixels per frame.
REQ-002 Parameter Y_MAX, default 720, vertical lines per frame.
REQ-003 Parameter COORD_W, default 11, coordinate width; SHALL satisfy 2^COORD_W >= max(X_MAX, Y_MAX).
REQ-004 Parameter DRAIN_CYCLES, default 4, pipeline depth flushed after the last pixel.
REQ-005 Parameter STALL_LIMIT, default 1023, watchdog threshold in gpuClock cycles.
REQ-006 gpuClock  in  1  sole clock, all logic on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 command  in  16  buffered host command word.
REQ-009 cmdValid  in  1  command qualifier, one-cycle strobe.
REQ-010 ramDone, flashDone  in  1 each  memory pipes have completed.
REQ-011 pixelFound  in  1  palette pipe holds a non-transparent pixel.
REQ-012 paletteX/paletteY, ramX/ramY, flashX/flashY  in  COORD_W each  per-pipe pixel positions.
REQ-013 rstPixelInc  out  1  active-low pixel-counter reset.
REQ-014 pipeAdvance  out  1  pipeline clock-enable; replaces the gated pipeline clock.
REQ-015 currentlyRendering  out  1  frame in progress.
REQ-016 gpuBusy  out  1  host-visible busy flag.
REQ-017 frameDone  out  1  one-cycle pulse at normal frame completion.
REQ-018 frameAbort  out  1  one-cycle pulse at watchdog abort.
REQ-019 frameCount  out  8  completed-frame counter.

Function
REQ-020 The FSM SHALL have the states IDLE, CLEAR, RENDER, DRAIN and DONE, encoded in the package.
REQ-021 IDLE->CLEAR SHALL occur when cmdValid=1 and command==16'h0001; all other commands in IDLE SHALL be ignored.
REQ-022 CLEAR SHALL last exactly one cycle with rstPixelInc=0, then go to RENDER.
REQ-023 In RENDER, pipeAdvance SHALL be 1 when (ramDone && flashDone), or when (pixelFound && palette XY == ram XY == flash XY); otherwise 0.
REQ-024 RENDER->DRAIN SHALL occur in the cycle pipeAdvance=1 with pixelFound=1 and paletteX==X_MAX-1 and paletteY==Y_MAX-1.
REQ-025 DRAIN SHALL assert pipeAdvance for DRAIN_CYCLES consecutive cycles, then go to DONE.
REQ-026 DONE SHALL last one cycle, pulse frameDone, increment frameCount (wrapping 255->0), then go to IDLE.
REQ-027 A start command received outside IDLE SHALL be dropped and no queueing SHALL occur.
REQ-028 currentlyRendering SHALL be 1 in CLEAR, RENDER and DRAIN.
REQ-029 gpuBusy SHALL be currentlyRendering || !(ramDone && flashDone).
REQ-030 pipeAdvance SHALL be 0 in IDLE, CLEAR and DONE.
REQ-031 All outputs SHALL be registered; pipeAdvance SHALL be generated from a single rising-edge flop with no combinational clock gating.

Reset
REQ-032 On reset assertion the FSM SHALL enter IDLE immediately (asynchronously), including mid-frame, with no frameDone pulse.
REQ-033 Reset values SHALL be: rstPixelInc=1, pipeAdvance=0, currentlyRendering=0, frameDone=0, frameAbort=0, frameCount=0, stall counter=0.
REQ-034 After reset deassertion the first start command SHALL be honoured no earlier than the following rising edge.

Configuration
REQ-035 Macro RENDER_STALL_WDT_EN SHALL control the stall watchdog.
REQ-036 With RENDER_STALL_WDT_EN defined, an internal counter SHALL increment each RENDER cycle in which pipeAdvance=0, and SHALL clear when pipeAdvance=1.
REQ-037 With RENDER_STALL_WDT_EN defined, when that counter reaches STALL_LIMIT the FSM SHALL go to IDLE, pulse frameAbort and leave frameCount unchanged.
REQ-038 Without RENDER_STALL_WDT_EN, the counter SHALL be absent, frameAbort SHALL be tied to 0, and RENDER SHALL wait indefinitely.

Structure
REQ-039 Package render_pkg SHALL hold the FSM state typedef, CMD_UPDATE_FRAME=16'h0001, and the default X_MAX/Y_MAX constants.
REQ-040 The watchdog SHALL be a sub-module stall_watchdog (counter, limit compare and clear), instantiated only under RENDER_STALL_WDT_EN.

Verification
REQ-041 Reset mid-RENDER at pixel (100,50) -> next edge shows IDLE, currentlyRendering=0 and frameCount unchanged.
REQ-042 Start with X_MAX=4, Y_MAX=2 and done signals held at 1 -> CLEAR for 1 cycle, 8 advance cycles, 4 drain cycles, then a frameDone pulse with frameCount=1.
REQ-043 ramDone=0 with pixelFound=1 and all XY=(3,1) -> pipeAdvance=1; the same case with flashX=2 -> pipeAdvance=0.
REQ-044 Second start command issued during RENDER -> ignored; exactly one frameDone pulse results.
REQ-045 With RENDER_STALL_WDT_EN defined, STALL_LIMIT=8 and ramDone held at 0 -> frameAbort pulses on the 8th stalled cycle and the FSM returns to IDLE.
REQ-046 Run 256 frames back-to-back -> frameCount wraps to 0 and gpuBusy falls after each frameDone.
